// File: rtl/rom_port_arbiter.sv
// Shares the program ROM's single combinational read port between instruction fetch (F)
// and constant loads (D); one grant per cycle, registered response one cycle later.
module rom_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  f_valid,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_ready,
    input  logic                  f_flush,
    output logic                  f_resp_valid,
    output logic [31:0]           f_resp_data,
    output logic                  f_resp_err,

    input  logic                  d_valid,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_ready,
    output logic                  d_resp_valid,
    output logic [31:0]           d_resp_data,
    output logic                  d_resp_err,

    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [31:0]           rom_out
);

    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_F = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] starve_cnt;
    logic [CNT_WIDTH-1:0] starve_cnt_nxt;
    logic                 starved;
    logic                 f_misaligned;
    logic                 d_misaligned;

    // A zero limit means fetch always has priority; avoids a constant unsigned compare.
    generate
        if (STARVE_LIMIT == 0) begin : g_strict
            assign starved = 1'b1;
        end else begin : g_limit
            assign starved = (starve_cnt >= LIMIT);
        end
    endgenerate

    assign f_misaligned = |f_addr[1:0];
    assign d_misaligned = |d_addr[1:0];

    // State and starvation counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Grant, address mux, response-valid decode and next state
    always_comb begin
        state_nxt      = IDLE;
        f_ready        = 1'b0;
        d_ready        = 1'b0;
        f_resp_valid   = 1'b0;
        d_resp_valid   = 1'b0;
        rom_address    = f_addr;
        starve_cnt_nxt = '0;

        if (!reset) begin
            f_ready      = f_valid & ~f_flush & (~d_valid | starved);
            d_ready      = d_valid & ~f_ready;
            f_resp_valid = (state == RESP_F) & ~f_flush;
            d_resp_valid = (state == RESP_D);
        end

        if (d_ready) begin
            rom_address = d_addr;
        end

        if (f_ready) begin
            state_nxt = RESP_F;
        end else if (d_ready) begin
            state_nxt = RESP_D;
        end

        // Count cycles a live fetch is held off; saturates at the limit
        if (f_valid && !f_flush && !f_ready) begin
            starve_cnt_nxt = starved ? starve_cnt : starve_cnt + CNT_WIDTH'(1);
        end
    end

    // Response capture; the non-granted port keeps its last word and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            f_resp_data <= '0;
            f_resp_err  <= 1'b0;
            d_resp_data <= '0;
            d_resp_err  <= 1'b0;
        end else begin
            if (f_ready) begin
                f_resp_data <= f_misaligned ? DATA_WIDTH'(0) : rom_out;
                f_resp_err  <= f_misaligned;
            end
            if (d_ready) begin
                d_resp_data <= d_misaligned ? DATA_WIDTH'(0) : rom_out;
                d_resp_err  <= d_misaligned;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: instance 0 uses STARVE_LIMIT=3, instance 1 uses STARVE_LIMIT=0.
module tb_rom_port_arbiter;

    logic clk;
    logic rst;
    logic [1:0]       fv, ff, dv;
    logic [1:0][7:0]  fa, da;
    logic [1:0]       fr, dr, frv, fre, drv, dre;
    logic [1:0][31:0] frd, drd, ro;
    logic [1:0][7:0]  ra;
    logic [31:0]      rom_mem [64];

    int checks = 0;
    int errors = 0;
    int lim [2] = '{3, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ro[0] = rom_mem[ra[0][7:2]];
    assign ro[1] = rom_mem[ra[1][7:2]];

    rom_port_arbiter #(.STARVE_LIMIT(3), .CNT_WIDTH(4), .ADDR_WIDTH(8)) dut_a (
        .clk(clk), .reset(rst),
        .f_valid(fv[0]), .f_addr(fa[0]), .f_ready(fr[0]), .f_flush(ff[0]),
        .f_resp_valid(frv[0]), .f_resp_data(frd[0]), .f_resp_err(fre[0]),
        .d_valid(dv[0]), .d_addr(da[0]), .d_ready(dr[0]),
        .d_resp_valid(drv[0]), .d_resp_data(drd[0]), .d_resp_err(dre[0]),
        .rom_address(ra[0]), .rom_out(ro[0])
    );

    rom_port_arbiter #(.STARVE_LIMIT(0), .CNT_WIDTH(4), .ADDR_WIDTH(8)) dut_b (
        .clk(clk), .reset(rst),
        .f_valid(fv[1]), .f_addr(fa[1]), .f_ready(fr[1]), .f_flush(ff[1]),
        .f_resp_valid(frv[1]), .f_resp_data(frd[1]), .f_resp_err(fre[1]),
        .d_valid(dv[1]), .d_addr(da[1]), .d_ready(dr[1]),
        .d_resp_valid(drv[1]), .d_resp_data(drd[1]), .d_resp_err(dre[1]),
        .rom_address(ra[1]), .rom_out(ro[1])
    );

    // Same request to both instances, applied on the falling edge
    task automatic drive(input logic f_v, input logic [7:0] f_a, input logic f_f,
                         input logic d_v, input logic [7:0] d_a);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            fv[i] = f_v; fa[i] = f_a; ff[i] = f_f; dv[i] = d_v; da[i] = d_a;
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        fv = '0; ff = '0; dv = '0; fa = '0; da = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (fr[i] !== 1'b0) begin errors++; $display("FAIL reset_f_ready[%0d]: got %b want 0", i, fr[i]); end
            checks++; if (dr[i] !== 1'b0) begin errors++; $display("FAIL reset_d_ready[%0d]: got %b want 0", i, dr[i]); end
            checks++; if (frv[i] !== 1'b0 || drv[i] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d]: got f=%b d=%b want 0", i, frv[i], drv[i]); end
            checks++; if (fre[i] !== 1'b0 || dre[i] !== 1'b0) begin errors++; $display("FAIL reset_resp_err[%0d]: got f=%b d=%b want 0", i, fre[i], dre[i]); end
            checks++; if (frd[i] !== 32'h0 || drd[i] !== 32'h0) begin errors++; $display("FAIL reset_resp_data[%0d]: got f=%h d=%h want 0", i, frd[i], drd[i]); end
        end
    endtask

    task automatic test_basic_fetch();
        drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (fr[i] !== 1'b1 || dr[i] !== 1'b0) begin errors++; $display("FAIL fetch_grant[%0d]: got f=%b d=%b want f=1 d=0", i, fr[i], dr[i]); end
            checks++; if (ra[i] !== 8'h04) begin errors++; $display("FAIL fetch_rom_address[%0d]: got %h want 04", i, ra[i]); end
        end
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (frv[i] !== 1'b1 || drv[i] !== 1'b0) begin errors++; $display("FAIL fetch_resp_valid[%0d]: got f=%b d=%b want f=1 d=0", i, frv[i], drv[i]); end
            checks++; if (frd[i] !== 32'hDEADBEEF || fre[i] !== 1'b0) begin errors++; $display("FAIL fetch_resp_data[%0d]: got %h err=%b want deadbeef err=0", i, frd[i], fre[i]); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (frv[i] !== 1'b1 || frd[i] !== 32'h00000013) begin errors++; $display("FAIL fetch_b2b[%0d]: got v=%b %h want v=1 00000013", i, frv[i], frd[i]); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (frv[i] !== 1'b0 || frd[i] !== 32'h00000013) begin errors++; $display("FAIL fetch_hold[%0d]: got v=%b %h want v=0 00000013", i, frv[i], frd[i]); end
        end
    endtask

    task automatic test_starvation();
        logic prev_f [2];
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 8'h00, 1'b0, 1'b1, 8'h04);
            for (int i = 0; i < 2; i++) begin
                logic ef;
                ef = (i == 1) ? 1'b1 : ((c % 4) == 3);
                checks++; if (fr[i] !== ef || dr[i] !== !ef) begin errors++; $display("FAIL starve_grant[%0d] c%0d: got f=%b d=%b want f=%b", i, c, fr[i], dr[i], ef); end
                checks++; if (ra[i] !== (ef ? 8'h00 : 8'h04)) begin errors++; $display("FAIL starve_addr[%0d] c%0d: got %h", i, c, ra[i]); end
                if (c > 0) begin
                    checks++;
                    if (prev_f[i] ? (frv[i] !== 1'b1 || drv[i] !== 1'b0 || frd[i] !== 32'h13)
                                  : (drv[i] !== 1'b1 || frv[i] !== 1'b0 || drd[i] !== 32'hDEADBEEF)) begin
                        errors++; $display("FAIL starve_resp[%0d] c%0d: got fv=%b dv=%b f=%h d=%h", i, c, frv[i], drv[i], frd[i], drd[i]);
                    end
                end
                prev_f[i] = ef;
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (frv[i] !== 1'b1 || drv[i] !== 1'b0) begin errors++; $display("FAIL starve_last_resp[%0d]: got f=%b d=%b want f=1 d=0", i, frv[i], drv[i]); end
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h06);
        for (int i = 0; i < 2; i++) begin
            checks++; if (dr[i] !== 1'b1 || fr[i] !== 1'b0 || ra[i] !== 8'h06) begin errors++; $display("FAIL mis_grant[%0d]: got d=%b f=%b addr=%h want d=1 f=0 06", i, dr[i], fr[i], ra[i]); end
        end
        drive(1'b1, 8'h05, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (drv[i] !== 1'b1 || dre[i] !== 1'b1 || drd[i] !== 32'h0) begin errors++; $display("FAIL mis_d_resp[%0d]: got v=%b err=%b %h want 1 1 0", i, drv[i], dre[i], drd[i]); end
            checks++; if (frv[i] !== 1'b0 || frd[i] !== 32'hDEADBEEF || fre[i] !== 1'b0) begin errors++; $display("FAIL mis_f_hold[%0d]: got v=%b %h err=%b want 0 deadbeef 0", i, frv[i], frd[i], fre[i]); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (frv[i] !== 1'b1 || fre[i] !== 1'b1 || frd[i] !== 32'h0) begin errors++; $display("FAIL mis_f_resp[%0d]: got v=%b err=%b %h want 1 1 0", i, frv[i], fre[i], frd[i]); end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 8'h00, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (frv[i] !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]: got f_resp_valid=%b want 0", i, frv[i]); end
            checks++; if (fr[i] !== 1'b0 || dr[i] !== 1'b1 || ra[i] !== 8'h00) begin errors++; $display("FAIL flush_d_grant[%0d]: got f=%b d=%b addr=%h want 0 1 00", i, fr[i], dr[i], ra[i]); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++; if (drv[i] !== 1'b1 || drd[i] !== 32'h13 || frv[i] !== 1'b0) begin errors++; $display("FAIL flush_d_resp[%0d]: got dv=%b %h fv=%b want 1 00000013 0", i, drv[i], drd[i], frv[i]); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h04);
        for (int i = 0; i < 2; i++) begin
            checks++; if (dr[i] !== 1'b1) begin errors++; $display("FAIL rstmid_grant[%0d]: got %b want 1", i, dr[i]); end
        end
        @(negedge clk);
        rst = 1'b1;
        fv = '0; dv = '0; ff = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (drv[i] !== 1'b0) begin errors++; $display("FAIL rstmid_no_deliver[%0d]: got %b want 0", i, drv[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (drv[i] !== 1'b0 || frv[i] !== 1'b0 || fr[i] !== 1'b0 || dr[i] !== 1'b0 ||
                drd[i] !== 32'h0 || frd[i] !== 32'h0 || dre[i] !== 1'b0 || fre[i] !== 1'b0) begin
                errors++; $display("FAIL rstmid_outputs[%0d]: got dv=%b fv=%b d=%h f=%h want all 0", i, drv[i], frv[i], drd[i], frd[i]);
            end
        end
    endtask

    // Randomized traffic against a streak-counting reference model
    task automatic test_random();
        int         denied [2];
        int         pend   [2];
        logic [31:0] fdat [2], ddat [2];
        logic       ferr [2], derr [2], fwait [2], dwait [2];
        for (int i = 0; i < 2; i++) begin
            denied[i] = 0; pend[i] = 0; fdat[i] = '0; ddat[i] = '0;
            ferr[i] = 1'b0; derr[i] = 1'b0; fwait[i] = 1'b0; dwait[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        fv = '0; dv = '0; ff = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
                logic [7:0] a;
                if (!fwait[i]) begin
                    a = 8'($urandom);
                    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    fv[i] = ($urandom_range(0, 2) != 0);
                    fa[i] = a;
                end
                if (!dwait[i]) begin
                    a = 8'($urandom);
                    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    dv[i] = ($urandom_range(0, 2) != 0);
                    da[i] = a;
                end
                ff[i] = ($urandom_range(0, 7) == 0);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                logic ef, ed;
                logic [7:0] eaddr;
                ef = fv[i] && !ff[i] && (!dv[i] || denied[i] >= lim[i]);
                ed = dv[i] && !ef;
                eaddr = ed ? da[i] : fa[i];
                checks++;
                if (fr[i] !== ef || dr[i] !== ed || ra[i] !== eaddr) begin
                    errors++; $display("FAIL rand_grant[%0d] n%0d: got f=%b d=%b a=%h want f=%b d=%b a=%h", i, n, fr[i], dr[i], ra[i], ef, ed, eaddr);
                end
                checks++;
                if (frv[i] !== (pend[i] == 1 && !ff[i]) || frd[i] !== fdat[i] || fre[i] !== ferr[i]) begin
                    errors++; $display("FAIL rand_f_resp[%0d] n%0d: got v=%b %h e=%b want v=%b %h e=%b", i, n, frv[i], frd[i], fre[i], (pend[i] == 1 && !ff[i]), fdat[i], ferr[i]);
                end
                checks++;
                if (drv[i] !== (pend[i] == 2) || drd[i] !== ddat[i] || dre[i] !== derr[i]) begin
                    errors++; $display("FAIL rand_d_resp[%0d] n%0d: got v=%b %h e=%b want v=%b %h e=%b", i, n, drv[i], drd[i], dre[i], (pend[i] == 2), ddat[i], derr[i]);
                end
                if (ef) begin
                    pend[i] = 1;
                    ferr[i] = (fa[i][1:0] != 2'b00);
                    fdat[i] = ferr[i] ? 32'h0 : rom_mem[fa[i][7:2]];
                end else if (ed) begin
                    pend[i] = 2;
                    derr[i] = (da[i][1:0] != 2'b00);
                    ddat[i] = derr[i] ? 32'h0 : rom_mem[da[i][7:2]];
                end else begin
                    pend[i] = 0;
                end
                denied[i] = (fv[i] && !ff[i] && !ef) ? denied[i] + 1 : 0;
                fwait[i]  = fv[i] && !ff[i] && !ef;
                dwait[i]  = dv[i] && !ed;
            end
        end
    endtask

    initial begin
        rom_mem[0] = 32'h00000013;
        rom_mem[1] = 32'hDEADBEEF;
        for (int k = 2; k < 64; k++) rom_mem[k] = $urandom;
        rst = 1'b1;
        fv = '0; ff = '0; dv = '0; fa = '0; da = '0;
        test_reset();
        test_basic_fetch();
        test_starvation();
        test_misaligned();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
